// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the cpu step controller: controller states and bus width.
package cpu_ctrl_pkg;

  localparam int ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    BREAK = 2'd2,
    BURST = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for an already debounced request level; the previous
// level is held in a register that clears on the synchronous reset.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic pulse
);

  logic req_q_r;

  // previous sample of the request level
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q_r <= 1'b0;
    end else begin
      req_q_r <= req;
    end
  end

  assign pulse = req & ~req_q_r;

endmodule

// File: rtl/cpu_step_controller.sv
// Clock-enable sequencer for the 6502 core: halt, single-step and divided free-run,
// with an address breakpoint and a tick counter. Define STEP_BURST_EN for multi-tick steps.
module cpu_step_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int RATE_WIDTH  = 18,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   step_req,
  input  logic                   run_req,
  input  logic [RATE_WIDTH-1:0]  rate_div,
  input  logic                   bp_en,
  input  logic [ADDR_WIDTH-1:0]  bp_addr,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
`ifdef STEP_BURST_EN
  input  logic [7:0]             step_n,
`endif
  output logic                   cpu_tick,
  output logic                   running,
  output logic                   bp_hit,
  output logic [COUNT_WIDTH-1:0] cycle_count
);

  localparam logic [RATE_WIDTH-1:0] DIV_ZERO = {RATE_WIDTH{1'b0}};
  localparam logic [RATE_WIDTH-1:0] DIV_ONE  = {{(RATE_WIDTH-1){1'b0}}, 1'b1};

  ctrl_state_e           state_r, state_s;
  logic [RATE_WIDTH-1:0] div_r, div_s;
  logic [RATE_WIDTH-1:0] period_last_s;
  logic [RATE_WIDTH-1:0] div_inc_s;
  logic                  div_wrap_s;
  logic                  tick_s;
  logic                  skip_r, skip_s;
  logic                  skip_tick_r;
  logic                  check_pending_r;
  logic                  check_hit_s;
  logic                  step_edge_s, run_edge_s;
`ifdef STEP_BURST_EN
  logic [7:0]            burst_cnt_r, burst_cnt_s;
  logic [7:0]            burst_len_s;
`endif

  edge_detect u_step_edge (
    .clk   (clk),
    .reset (reset),
    .req   (step_req),
    .pulse (step_edge_s)
  );

  edge_detect u_run_edge (
    .clk   (clk),
    .reset (reset),
    .req   (run_req),
    .pulse (run_edge_s)
  );

  // divider terminal value, breakpoint match and next-state decode
  always_comb begin
    state_s    = state_r;
    div_s      = div_r;
    skip_s     = skip_r;
    tick_s     = 1'b0;
`ifdef STEP_BURST_EN
    burst_cnt_s = burst_cnt_r;
    burst_len_s = (step_n == 8'd0) ? 8'd1 : step_n;
`endif
    // a period of max(rate_div,1)+1 means the divider tops out at max(rate_div,1)
    period_last_s = (rate_div == DIV_ZERO) ? DIV_ONE : rate_div;
    div_wrap_s    = (div_r >= period_last_s);
    div_inc_s     = div_wrap_s ? DIV_ZERO : (div_r + DIV_ONE);
`ifdef STEP_BURST_EN
    check_hit_s = check_pending_r && bp_en && (cpu_addr == bp_addr) &&
                  ((state_r == RUN) || (state_r == BURST));
`else
    check_hit_s = check_pending_r && bp_en && (cpu_addr == bp_addr) && (state_r == RUN);
`endif

    case (state_r)
      HALT: begin
        if (run_edge_s) begin
          state_s = RUN;
          div_s   = DIV_ZERO;
          skip_s  = 1'b0;
        end else if (step_edge_s) begin
`ifdef STEP_BURST_EN
          state_s     = BURST;
          div_s       = DIV_ZERO;
          skip_s      = 1'b0;
          burst_cnt_s = burst_len_s;
`else
          tick_s = 1'b1;
`endif
        end else begin
          state_s = HALT;
        end
      end
      RUN: begin
        if (run_edge_s) begin
          state_s = HALT;
          div_s   = DIV_ZERO;
        end else if (check_hit_s) begin
          state_s = BREAK;
          div_s   = DIV_ZERO;
        end else begin
          div_s  = div_inc_s;
          tick_s = div_wrap_s;
        end
      end
      BREAK: begin
        // resuming marks the next tick so its own breakpoint check is skipped
        if (run_edge_s) begin
          state_s = RUN;
          div_s   = DIV_ZERO;
          skip_s  = 1'b1;
        end else if (step_edge_s) begin
`ifdef STEP_BURST_EN
          state_s     = BURST;
          div_s       = DIV_ZERO;
          skip_s      = 1'b1;
          burst_cnt_s = burst_len_s;
`else
          state_s = HALT;
          tick_s  = 1'b1;
`endif
        end else begin
          state_s = BREAK;
        end
      end
`ifdef STEP_BURST_EN
      BURST: begin
        if (run_edge_s) begin
          state_s = RUN;
        end else if (check_hit_s) begin
          state_s = BREAK;
          div_s   = DIV_ZERO;
        end else if (burst_cnt_r == 8'd0) begin
          // hold one extra cycle so the last tick still gets its breakpoint check
          if (!cpu_tick) begin
            state_s = HALT;
            div_s   = DIV_ZERO;
          end else begin
            state_s = BURST;
          end
        end else begin
          div_s  = div_inc_s;
          tick_s = div_wrap_s;
          if (div_wrap_s) begin
            burst_cnt_s = burst_cnt_r - 8'd1;
          end else begin
            burst_cnt_s = burst_cnt_r;
          end
        end
      end
`endif
      default: begin
        state_s = HALT;
        div_s   = DIV_ZERO;
      end
    endcase

    if (tick_s) begin
      skip_s = 1'b0;
    end else begin
      skip_s = skip_s;
    end
  end

  // state, divider, breakpoint bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= HALT;
      div_r           <= DIV_ZERO;
      skip_r          <= 1'b0;
      skip_tick_r     <= 1'b0;
      check_pending_r <= 1'b0;
      cpu_tick        <= 1'b0;
      running         <= 1'b0;
      bp_hit          <= 1'b0;
      cycle_count     <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_r         <= state_s;
      div_r           <= div_s;
      skip_r          <= skip_s;
      skip_tick_r     <= tick_s & skip_r;
      check_pending_r <= cpu_tick & ~skip_tick_r;
      cpu_tick        <= tick_s;
      running         <= (state_s == RUN);
      bp_hit          <= (state_s == BREAK);
      cycle_count     <= cycle_count + {{(COUNT_WIDTH-1){1'b0}}, cpu_tick};
    end
  end

`ifdef STEP_BURST_EN
  // remaining ticks of the current step burst
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt_r <= 8'd0;
    end else begin
      burst_cnt_r <= burst_cnt_s;
    end
  end
`endif

endmodule
